// File: rtl/core_pkg.sv
// Shared constants for the five-stage core: default PC layout, stage indices
// and instruction alignment.
package core_pkg;

    localparam int          CORE_XLEN        = 32;
    localparam logic [31:0] CORE_RESET_PC    = 32'h0100_0000;
    localparam logic [31:0] CORE_TRAP_VECTOR = 32'h0100_0100;
    localparam int          CORE_INC         = 4;

    localparam int STG_DEC = 0;
    localparam int STG_EXE = 1;
    localparam int STG_MEM = 2;
    localparam int STG_WB  = 3;

    // Instructions are word aligned; these low PC bits are always zero.
    localparam int ALIGN_BITS = 2;

endpackage

// File: rtl/pc_stage_reg.sv
// One PC+valid pipeline slot: hold keeps the slot, otherwise it loads the
// upstream copy; kill forces the captured valid low in either case.
module pc_stage_reg #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            hold,
    input  logic            kill,
    input  logic [XLEN-1:0] pc_in,
    input  logic            valid_in,
    output logic [XLEN-1:0] pc_out,
    output logic            valid_out
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;

    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q & ~kill;
        if (!hold) begin
            pc_d    = pc_in;
            valid_d = valid_in & ~kill;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign pc_out    = pc_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/pc_pipe_unit.sv
// Fetch-PC generator with a shadow pipeline of per-stage PC/valid copies,
// handling stall bubbles, execute-stage redirects and trap flushes.
module pc_pipe_unit
    import core_pkg::*;
#(
    parameter int              XLEN           = CORE_XLEN,
    parameter logic [XLEN-1:0] RESET_PC       = XLEN'(CORE_RESET_PC),
    parameter logic [XLEN-1:0] TRAP_VECTOR    = XLEN'(CORE_TRAP_VECTOR),
    parameter int              STAGES         = 4,
    parameter int              REDIRECT_STAGE = STG_EXE,
    parameter int              INC            = CORE_INC
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_target,
    input  logic                     trap_valid,
    output logic [XLEN-1:0]          pc,
    output logic [XLEN-1:0]          pc_plus_inc,
    output logic [STAGES*XLEN-1:0]   stage_pc,
    output logic [STAGES-1:0]        stage_valid,
    output logic                     misalign_err
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_err_q, misalign_err_d;
    logic [XLEN-1:0] aligned_target;

    logic [STAGES-1:0] slot_hold;
    logic [STAGES-1:0] slot_kill;
    logic [XLEN-1:0]   slot_pc_in  [STAGES];
    logic              slot_vld_in [STAGES];
    logic [XLEN-1:0]   slot_pc     [STAGES];
    logic              slot_vld    [STAGES];

    assign aligned_target = {redirect_target[XLEN-1:ALIGN_BITS], ALIGN_BITS'(0)};
    assign pc_plus_inc    = pc_q + XLEN'(INC);

    always_comb begin
        pc_d           = pc_plus_inc;
        misalign_err_d = redirect_valid & (|redirect_target[ALIGN_BITS-1:0]);
        if (trap_valid) begin
            pc_d = TRAP_VECTOR;
        end else if (redirect_valid) begin
            pc_d = aligned_target;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    // Slot controls: trap kills everything, redirect kills the wrong-path
    // slots up to the redirecting stage, a bare stall freezes decode and
    // pushes a bubble into the next slot.
    always_comb begin
        slot_hold = '0;
        for (int k = 0; k < STAGES; k++) begin
            slot_kill[k] = trap_valid | (redirect_valid & (k <= REDIRECT_STAGE));
        end
        if (stall && !redirect_valid && !trap_valid) begin
            slot_hold[0] = 1'b1;
            slot_kill[1] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q           <= RESET_PC;
            misalign_err_q <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    assign slot_pc_in[0]  = pc_q;
    assign slot_vld_in[0] = 1'b1;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k > 0) begin : g_link
            assign slot_pc_in[k]  = slot_pc[k-1];
            assign slot_vld_in[k] = slot_vld[k-1];
        end

        pc_stage_reg #(.XLEN(XLEN)) u_slot (
            .clock     (clock),
            .reset     (reset),
            .hold      (slot_hold[k]),
            .kill      (slot_kill[k]),
            .pc_in     (slot_pc_in[k]),
            .valid_in  (slot_vld_in[k]),
            .pc_out    (slot_pc[k]),
            .valid_out (slot_vld[k])
        );

        assign stage_pc[k*XLEN +: XLEN] = slot_pc[k];
        assign stage_valid[k]           = slot_vld[k];
    end

    assign pc           = pc_q;
    assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_pc_pipe_unit.sv
// Bench for pc_pipe_unit: directed scenarios then random traffic, compared
// each cycle against an array-based model of the fetch pipeline.
module tb_pc_pipe_unit;

    localparam int          XLEN    = 32;
    localparam int          STAGES  = 4;
    localparam int          RSTG    = 1;
    localparam logic [31:0] RST_PC  = 32'h0100_0000;
    localparam logic [31:0] TRAP_PC = 32'h0100_0100;

    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    logic                     stall = 1'b0;
    logic                     redirect_valid = 1'b0;
    logic [XLEN-1:0]          redirect_target = '0;
    logic                     trap_valid = 1'b0;
    logic [XLEN-1:0]          pc;
    logic [XLEN-1:0]          pc_plus_inc;
    logic [STAGES*XLEN-1:0]   stage_pc;
    logic [STAGES-1:0]        stage_valid;
    logic                     misalign_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_spc   [STAGES];
    bit          m_sv    [STAGES];
    bit          m_known [STAGES];
    bit          m_mis;

    pc_pipe_unit dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .pc              (pc),
        .pc_plus_inc     (pc_plus_inc),
        .stage_pc        (stage_pc),
        .stage_valid     (stage_valid),
        .misalign_err    (misalign_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [31:0] n_spc [STAGES];
        bit          n_sv  [STAGES];
        bit          n_kn  [STAGES];
        if (reset) begin
            m_pc  = RST_PC;
            m_mis = 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                m_spc[k] = '0; m_sv[k] = 1'b0; m_known[k] = 1'b1;
            end
            return;
        end
        m_mis = redirect_valid && (redirect_target[1:0] != 2'b00);
        n_spc[0] = m_pc; n_sv[0] = 1'b1; n_kn[0] = 1'b1;
        for (int k = 1; k < STAGES; k++) begin
            n_spc[k] = m_spc[k-1]; n_sv[k] = m_sv[k-1]; n_kn[k] = m_known[k-1];
        end
        if (trap_valid) begin
            for (int k = 0; k < STAGES; k++) begin
                n_sv[k] = 1'b0; n_kn[k] = 1'b0;
            end
            m_pc = TRAP_PC;
        end else if (redirect_valid) begin
            for (int k = 0; k <= RSTG; k++) n_sv[k] = 1'b0;
            m_pc = {redirect_target[31:2], 2'b00};
        end else if (stall) begin
            n_spc[0] = m_spc[0]; n_sv[0] = m_sv[0]; n_kn[0] = m_known[0];
            n_spc[1] = m_spc[0]; n_sv[1] = 1'b0;    n_kn[1] = m_known[0];
        end else begin
            m_pc = m_pc + 32'd4;
        end
        for (int k = 0; k < STAGES; k++) begin
            m_spc[k] = n_spc[k]; m_sv[k] = n_sv[k]; m_known[k] = n_kn[k];
        end
    endtask

    task automatic check_all();
        check("pc", pc, m_pc);
        check("pc_plus_inc", pc_plus_inc, m_pc + 32'd4);
        check("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
        for (int k = 0; k < STAGES; k++) begin
            check($sformatf("stage_valid[%0d]", k), {31'd0, stage_valid[k]}, {31'd0, m_sv[k]});
            if (m_known[k])
                check($sformatf("stage_pc[%0d]", k), stage_pc[k*XLEN +: XLEN], m_spc[k]);
        end
    endtask

    task automatic cycle(input bit rs, input bit st, input bit rv,
                         input logic [31:0] tg, input bit tr);
        reset = rs; stall = st; redirect_valid = rv; redirect_target = tg; trap_valid = tr;
        @(posedge clock);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        m_pc = '0;
        m_mis = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            m_spc[k] = '0; m_sv[k] = 1'b0; m_known[k] = 1'b0;
        end

        cycle(1, 0, 0, 32'h0, 0);
        cycle(1, 0, 0, 32'h0, 0);
        check("reset_pc", pc, 32'h0100_0000);
        check("reset_valid", {28'd0, stage_valid}, 32'h0);

        repeat (4) cycle(0, 0, 0, 32'h0, 0);
        check("free_run_pc", pc, 32'h0100_0010);

        cycle(0, 1, 0, 32'h0, 0);
        cycle(0, 1, 0, 32'h0, 0);
        check("stall_pc_hold", pc, 32'h0100_0010);
        check("stall_stage0_hold", stage_pc[31:0], 32'h0100_000C);

        cycle(0, 1, 1, 32'h0100_0200, 0);
        check("redirect_over_stall", pc, 32'h0100_0200);
        cycle(0, 0, 0, 32'h0, 0);

        cycle(0, 0, 1, 32'h0100_0203, 0);
        check("misalign_pulse", {31'd0, misalign_err}, 32'd1);
        cycle(0, 0, 0, 32'h0, 0);
        check("misalign_clear", {31'd0, misalign_err}, 32'd0);

        cycle(0, 0, 1, 32'h0100_0203, 1);
        check("trap_wins", pc, 32'h0100_0100);
        repeat (3) cycle(0, 0, 0, 32'h0, 0);

        cycle(0, 0, 1, 32'hFFFF_FFFC, 0);
        cycle(0, 0, 0, 32'h0, 0);
        check("pc_wrap", pc, 32'h0000_0000);
        cycle(0, 0, 0, 32'h0, 0);

        cycle(1, 1, 0, 32'h0, 0);
        check("mid_reset_pc", pc, 32'h0100_0000);

        for (int i = 0; i < 400; i++) begin
            bit          rs, st, rv, tr;
            logic [31:0] tg;
            rs = ($urandom_range(0, 59) == 0);
            st = ($urandom_range(0, 2) == 0);
            rv = ($urandom_range(0, 5) == 0);
            tr = ($urandom_range(0, 24) == 0);
            tg = $urandom;
            if ($urandom_range(0, 7) == 0) tg = 32'hFFFF_FFF0 | (tg & 32'hF);
            cycle(rs, st, rv, tg, tr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
